// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector family: limits, mode
// constants and a saturating increment used by counters in the FSM library.
package seq_det_pkg;

    localparam int PAT_LEN_MAX = 32;

    localparam int MODE_NONOVL = 0;
    localparam int MODE_OVL    = 1;

    // Returns value+1, but never exceeds limit.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] limit);
        return (value >= limit) ? limit : value + 32'd1;
    endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Bus bundle for seq_detect_param: serial data, pattern reload, counter
// clear, plus the detect pulse and match counter coming back.
interface seq_detect_param_if #(
    parameter int PAT_LEN = 5,
    parameter int CNT_W   = 8
);
    logic               d;
    logic               d_vld;
    logic               cfg_we;
    logic [PAT_LEN-1:0] cfg_pat;
    logic               cnt_clr;
    logic               pd;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;

    modport master (
        output d, d_vld, cfg_we, cfg_pat, cnt_clr,
        input  pd, match_cnt, cnt_sat
    );

    modport slave (
        input  d, d_vld, cfg_we, cfg_pat, cnt_clr,
        output pd, match_cnt, cnt_sat
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat is registered and is
// high exactly while the value sits at all-ones.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    logic [WIDTH-1:0] value_q, value_d;
    logic             sat_q, sat_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            value_d = WIDTH'(sat_inc(32'(value_q), 32'(MAX_VAL)));
        end
        sat_d = (value_d == MAX_VAL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            sat_q   <= sat_d;
        end
    end

    assign value = value_q;
    assign sat   = sat_q;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: compares a sliding window of valid
// input bits against a reloadable pattern and counts completed matches.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b00101,
    parameter int                 OVERLAP = MODE_NONOVL,
    parameter int                 CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    seq_detect_param_if.slave bus
);

    if (PAT_LEN < 2 || PAT_LEN > PAT_LEN_MAX) begin : g_bad_len
        $error("seq_detect_param: PAT_LEN out of range");
    end

    localparam int                FILL_W    = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_LEN - 1);
    localparam bit                KEEP_HIST = (OVERLAP == MODE_OVL);

    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               pd_q, pd_d;

    logic [PAT_LEN-1:0] window;
    logic               match;
    logic [CNT_W-1:0]   cnt_value;
    logic               cnt_sat_w;

    // The whole window is compared at once, so any partial prefix is
    // recovered exactly without a hand-built fallback state graph.
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        window = {hist_q, bus.d};
        match  = bus.d_vld && !bus.cfg_we && (fill_q == FILL_MAX) &&
                 (window == pat_q);

        if (bus.cfg_we) begin
            pat_d  = bus.cfg_pat;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.d_vld) begin
            if (match && !KEEP_HIST) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[PAT_LEN-2:0];
                fill_d = FILL_W'(sat_inc(32'(fill_q), 32'(FILL_MAX)));
            end
        end

        pd_d = match;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            pd_q   <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            pd_q   <= pd_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.cnt_clr),
        .inc   (match),
        .value (cnt_value),
        .sat   (cnt_sat_w)
    );

    assign bus.pd        = pd_q;
    assign bus.match_cnt = cnt_value;
    assign bus.cnt_sat   = cnt_sat_w;

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial pattern detector, the successor to the fixed 5-bit single-mode FSM detectors in the FSM library.
- Pattern length, reset-time pattern, overlap mode and counter width are parameters.
- The pattern is reloadable at run time, input is qualified by a valid strobe, and completed matches are counted.
- Sits on a serial bit stream and flags each complete occurrence of the pattern with a single-cycle registered pulse.

Parameters:
- PAT_LEN, 5, pattern length in bits, legal range 2..32.
- PATTERN, 5'b00101, reset pattern, PAT_LEN bits wide; MSB is the first bit received.
- OVERLAP, 0: 0 = non-overlapping (history discarded after a match); 1 = overlapping.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- d  input  1  serial data bit.
- d_vld  input  1  d is sampled only when 1.
- cfg_we  input  1  load cfg_pat as the new pattern.
- cfg_pat  input  PAT_LEN  new pattern, MSB first-received.
- cnt_clr  input  1  clear the match counter.
- pd  output  1  pattern-detected pulse.
- match_cnt  output  CNT_W  number of matches since reset or clear, saturating.
- cnt_sat  output  1  high while match_cnt is at all-ones.

Behaviour:
- Reset (rst=1 at an edge):
  - pat_q <= PATTERN; hist <= 0; fill <= 0.
  - pd=0, match_cnt=0, cnt_sat=0.
  - rst overrides every other input.
- State:
  - hist: PAT_LEN-1 bit history shift register.
  - fill: count of valid bits held, 0..PAT_LEN-1, saturating.
  - pat_q: pattern register.
- Window and match, evaluated combinationally each cycle:
  - window = {hist, d}.
  - match = d_vld && !cfg_we && (fill == PAT_LEN-1) && (window == pat_q).
- pd timing:
  - pd <= match, every cycle.
  - pd is high for exactly one cycle, the cycle after the edge that sampled the final pattern bit (1-cycle latency).
  - pd is 0 in every other cycle, including cycles where d_vld=0.
- Valid bit, no match: hist <= window[PAT_LEN-2:0]; fill <= min(fill+1, PAT_LEN-1).
- Valid bit with match:
  - OVERLAP=1: identical to the no-match update, so a suffix of the match may start the next one.
  - OVERLAP=0: hist <= 0, fill <= 0; the next match needs PAT_LEN fresh bits.
- d_vld=0: hist and fill hold; no match is possible.
- cfg_we=1 (priority over d_vld):
  - pat_q <= cfg_pat; hist <= 0; fill <= 0; pd <= 0.
  - The bit on d in that cycle is discarded.
  - match_cnt is unaffected.
- Counter:
  - cnt_clr=1: match_cnt <= 0, taking priority over an increment in the same cycle.
  - Otherwise match_cnt increments on match, holding at 2^CNT_W-1.
  - cnt_sat is registered: cnt_sat = (match_cnt == all-ones).
- Partial-prefix recovery is exact for any pattern, because the window compare replaces a hand-written fallback FSM. Example: pattern 00101 on stream 000101 matches at the 6th bit.
- Mid-stream reset discards partial history; no pd from bits sampled before the reset.

Decomposition:
- Shared package seq_det_pkg:
  - PAT_LEN_MAX = 32.
  - Mode constants MODE_NONOVL = 0, MODE_OVL = 1.
  - Saturating-increment helper function.
- One natural sub-module: sat_counter (parametrised width, clr, inc, value, sat), reusable by other FSM-library blocks.
- The detector core stays in seq_detect_param.

Test Plan:
1. Defaults, OVERLAP=0, d_vld=1, stream 0,0,1,0,1,0,0,1,0,1 -> pd pulses the cycle after bit 5 and after bit 10; match_cnt=2.
2. Defaults, stream 0,0,0,1,0,1 -> pd after bit 6 (prefix recovery); stream 0,0,1,1,0,1 -> no pd.
3. PAT_LEN=4, PATTERN=4'b0101:
   - OVERLAP=1, stream 0,1,0,1,0,1 -> pd after bits 4 and 6, match_cnt=2.
   - Same stream with OVERLAP=0 -> pd after bit 4 only, match_cnt=1.
4. Defaults, stream 0,0,1,0 then d_vld=0 for 3 cycles, then 1 -> pd after the final valid bit; no pd during the idle cycles.
5. cfg_we with cfg_pat=5'b11010 after bits 0,0,1,0 -> no pd on a following 1; then stream 1,1,0,1,0 -> one pd; match_cnt increments once.
6. CNT_W=2, five back-to-back matches -> match_cnt sticks at 3, cnt_sat=1; cnt_clr -> 0. rst asserted after 4 pattern bits, then the final bit -> no pd.
